scalable_op_pipe: RTL and testbench

SCALABLE_OP_PIPE -- requirements
Module: scalable_op_pipe

---
 rtl/scalable_pkg.sv | 15 +
 rtl/scalable_pipe_stage.sv | 32 +++
 rtl/scalable_op_pipe.sv | 97 +++++++++
 tb/tb_scalable_op_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/scalable_pkg.sv
// Shared types and defaults for the scalable operator pipeline.
// Holds the operation enum and the default width/depth constants.
package scalable_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_ADD = 2'd2,
    OP_SEL = 2'd3
  } op_mode_e;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_STAGES = 2;

endpackage

// File: rtl/scalable_pipe_stage.sv
// One elastic pipeline register: valid bit plus W-bit payload.
// Ports: clk, rst, prev_valid/prev_data (upstream), next_ready, valid/data.
module scalable_pipe_stage #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         prev_valid,
  input  logic [W-1:0] prev_data,
  input  logic         next_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic load;

  // Load when empty or when the current beat leaves this cycle.
  assign load = !valid || next_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/scalable_op_pipe.sv
// Elastic STAGES-deep pipeline applying AND/OR/ADD/SEL to operands.
// Ports: clk, rst, in_* (valid/ready/mode/operands), out_* (valid/ready/result/carry), res_count.
module scalable_op_pipe
  import scalable_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_0,
  output logic             out_carry,
  output logic [CNT_W-1:0] res_count
);

  logic [STAGES:0] vld;
  logic [STAGES-1:0] rdy;
  logic [WIDTH:0] dat [STAGES+1];
  logic [WIDTH:0] sum;
  logic [WIDTH:0] res;
  op_mode_e mode;

  assign mode = op_mode_e'(in_mode);
  assign sum  = {1'b0, in_0} + {1'b0, in_1};

  // Bit WIDTH of res is the carry; it is zero for the logic ops.
  always_comb begin
    res = '0;
    unique case (1'b1)
      mode == OP_AND: res = {1'b0, in_0 & in_1};
      mode == OP_OR:  res = {1'b0, in_0 | in_1};
      mode == OP_ADD: res = sum;
      mode == OP_SEL: res = (in_2 == '0) ? sum : {1'b0, in_1 & in_2};
      default:        res = '0;
    endcase
  end

  assign vld[0] = in_valid;
  assign dat[0] = res;

  // Stage k can load if any stage at or after it is empty, or the
  // output drains. Derived from registered valids only, so no loop.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc    = acc | ~vld[k+1];
      rdy[k] = acc;
    end
  end

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      logic nxt;
      if (i == STAGES - 1) begin : g_last
        assign nxt = out_ready;
      end else begin : g_mid
        assign nxt = rdy[i+1];
      end
      scalable_pipe_stage #(
        .W(WIDTH + 1)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .prev_valid(vld[i]),
        .prev_data (dat[i]),
        .next_ready(nxt),
        .valid     (vld[i+1]),
        .data      (dat[i+1])
      );
    end
  endgenerate

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES];
  assign out_0     = dat[STAGES][WIDTH-1:0];
  assign out_carry = dat[STAGES][WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_count <= '0;
    end else if (out_valid && out_ready) begin
      res_count <= res_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_scalable_op_pipe.sv
// Scoreboard bench for scalable_op_pipe (WIDTH 5, STAGES 2, CNT_W 4).
// Expected results are queued on acceptance and compared on delivery.
module tb_scalable_op_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_mode;
  logic [4:0] in_0, in_1, in_2;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_0;
  logic       out_carry;
  logic [3:0] res_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] q[$];
  logic [3:0] mcnt;
  logic       hold_v;
  logic [5:0] hold_d;
  bit         rand_rdy;

  scalable_op_pipe #(
    .WIDTH (5),
    .STAGES(2),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_0     (in_0),
    .in_1     (in_1),
    .in_2     (in_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_0    (out_0),
    .out_carry(out_carry),
    .res_count(res_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model(int m, int a, int b, int c);
    int s;
    s = a + b;
    if (m == 0) return 6'(a & b);
    if (m == 1) return 6'(a | b);
    if (m == 2 || c == 0) return 6'(s);
    return 6'(b & c);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt   = '0;
      hold_v = 1'b0;
    end else begin
      check("count", res_count, mcnt);
      if (q.size() == 0) check("idle", out_valid, 0);
      if (hold_v && out_valid) check("stable", {out_carry, out_0}, hold_d);
      if (out_valid && out_ready && q.size() != 0) begin
        check("data", {out_carry, out_0}, q.pop_front());
        mcnt = mcnt + 4'd1;
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_carry, out_0};
      if (in_valid && in_ready)
        q.push_back(model(int'(in_mode), int'(in_0), int'(in_1), int'(in_2)));
    end
  end

  task automatic drive_beat(input int m, input int a, input int b, input int c);
    bit took;
    took     = 1'b0;
    in_valid = 1'b1;
    in_mode  = 2'(m);
    in_0     = 5'(a);
    in_1     = 5'(b);
    in_2     = 5'(c);
    for (int n = 0; n < 100; n++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) break;
    end
    in_valid = 1'b0;
    check("accept_to", took, 1);
  endtask

  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain", q.size(), 0);
  endtask

  initial begin
    int lat;
    int acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = '0;
    in_0      = '0;
    in_1      = '0;
    in_2      = '0;
    out_ready = 1'b1;
    rand_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid", out_valid, 0);
    check("rst_out0", out_0, 0);
    check("rst_carry", out_carry, 0);
    check("rst_count", res_count, 0);
    rst = 1'b0;
    #1;
    check("rst_iready", in_ready, 1);

    // ADD with carry, plus latency measurement on an idle pipe
    drive_beat(2, 20, 15, 0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 2);
    check("add_out", out_0, 3);
    check("add_carry", out_carry, 1);
    drain();

    drive_beat(0, 5'b10110, 5'b01111, 0);
    drive_beat(1, 5'b10110, 5'b01111, 0);
    drive_beat(3, 3, 4, 0);
    drive_beat(3, 0, 5, 6);
    drain();

    // Backpressure: hold output for 4 cycles with continuous input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc       = 0;
    for (int i = 0; i < 4; i++) begin
      in_mode = 2'd2;
      in_0    = 5'(acc + 1);
      in_1    = 5'(acc * 7);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    check("stall_acc", acc, 2);
    check("stall_rdy", in_ready, 0);
    in_valid = 1'b0;
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive_beat(2, 9, 9, 0);
    drive_beat(1, 3, 12, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("flush_ovalid", out_valid, 0);
    check("flush_count", res_count, 0);
    check("flush_iready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Counter wrap: 17 deliveries on a 4-bit counter
    for (int i = 0; i < 17; i++) drive_beat(i % 4, i, 31 - i, i % 3);
    drain();
    check("wrap_count", res_count, 1);

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++)
      drive_beat($urandom_range(0, 3), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 3) == 0 ? 0 :
                 $urandom_range(1, 31));
    rand_rdy = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
